// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and stall controller for a five-stage in-order pipeline.
//
// There are three sources of pipeline control. They are listed here from
// highest to lowest priority:
//   1. Data-memory wait (freeze)
//      - Stall every stage register.
//      - Feed a NOP into MEM/WB.
//   2. Taken branch
//      - Redirect the PC.
//      - Squash IF/ID and ID/EX.
//   3. Load-use hazard
//      - Hold PC and IF/ID.
//      - Insert a bubble into ID/EX.
//
// A memory access that has not completed moves the FSM from RUN to MEMWAIT.
// The FSM returns to RUN in the cycle after mem_ready rises. A 4-bit wait
// counter drives the sticky mem_timeout flag. A 16-bit saturating counter
// accumulates the number of cycles in which the PC was held.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   IF_ID_readREG1/2, IF_ID_uses2     ID-stage source operands
//   ID_EX_memread, ID_EX_writeREG     EX-stage load and its destination
//   branch_taken                      EX resolves a taken branch
//   EX_MEM_memreq, mem_ready          MEM-stage access handshake
//   perf_clr                          sync clear of stall_cycles/mem_timeout
//   PCwrite, IF_ID_write,
//   ID_EX_write, EX_MEM_write         stage-register load enables
//   ID_EX_bubble, MEM_WB_bubble       NOP insertion
//   IF_ID_flush, ID_EX_flush          stage squash
//   PCsrc                             PC loads the branch target
//   stall_cycles                      saturating count of PCwrite=0 cycles
//   mem_timeout                       sticky memory-wait timeout
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  IF_ID_readREG1,
   input  logic [2:0]  IF_ID_readREG2,
   input  logic        IF_ID_uses2,
   input  logic        ID_EX_memread,
   input  logic [2:0]  ID_EX_writeREG,
   input  logic        branch_taken,
   input  logic        EX_MEM_memreq,
   input  logic        mem_ready,
   input  logic        perf_clr,
   output logic        PCwrite,
   output logic        IF_ID_write,
   output logic        ID_EX_write,
   output logic        EX_MEM_write,
   output logic        ID_EX_bubble,
   output logic        MEM_WB_bubble,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        PCsrc,
   output logic [15:0] stall_cycles,
   output logic        mem_timeout
);

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic        mem_timeout_q, mem_timeout_d;

   logic        freeze;
   logic        load_use;

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   // Register 0 is hard-wired, so a load that targets it never creates a
   // dependency.
   always_comb begin
      load_use = 1'b0;
      if (ID_EX_memread && (ID_EX_writeREG != 3'd0)) begin
         load_use = (ID_EX_writeREG == IF_ID_readREG1) ||
                    (IF_ID_uses2 && (ID_EX_writeREG == IF_ID_readREG2));
      end
   end

   // In MEMWAIT, the cycle in which mem_ready rises is already unfrozen. The
   // branch and load-use rules therefore act in that same cycle.
   always_comb begin
      freeze = 1'b0;
      unique case (state_q)
         RUN:     freeze = EX_MEM_memreq && !mem_ready;
         MEMWAIT: freeze = !mem_ready;
         default: freeze = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (freeze)    state_d = MEMWAIT;
         MEMWAIT: if (mem_ready) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   // Every control is held at 0 while reset is asserted. The gate is applied
   // combinationally, so the outputs are quiet even before the first clock
   // edge.
   always_comb begin
      PCwrite       = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_write  = 1'b0;
      ID_EX_bubble  = 1'b0;
      MEM_WB_bubble = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      PCsrc         = 1'b0;
      if (rst_n) begin
         if (freeze) begin
            MEM_WB_bubble = 1'b1;
         end else if (branch_taken) begin
            PCwrite      = 1'b1;
            IF_ID_write  = 1'b1;
            ID_EX_write  = 1'b1;
            EX_MEM_write = 1'b1;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            PCsrc        = 1'b1;
         end else if (load_use) begin
            ID_EX_write  = 1'b1;
            EX_MEM_write = 1'b1;
            ID_EX_bubble = 1'b1;
         end else begin
            PCwrite      = 1'b1;
            IF_ID_write  = 1'b1;
            ID_EX_write  = 1'b1;
            EX_MEM_write = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Wait counter, timeout flag, stall statistics
   // ---------------------------------------------------------------------------
   always_comb begin
      wait_cnt_d     = '0;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q;

      if (freeze && (wait_cnt_q != 4'hF)) begin
         wait_cnt_d = wait_cnt_q + 4'd1;
      end else if (freeze) begin
         wait_cnt_d = wait_cnt_q;
      end

      // perf_clr overrides both the set and the increment.
      if (perf_clr) begin
         mem_timeout_d  = 1'b0;
         stall_cycles_d = '0;
      end else begin
         if (freeze && (wait_cnt_q == 4'hF)) begin
            mem_timeout_d = 1'b1;
         end
         if (!PCwrite && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         stall_cycles_q <= '0;
         mem_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
         mem_timeout_q  <= mem_timeout_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  IF_ID_readREG1, IF_ID_readREG2;
   logic        IF_ID_uses2, ID_EX_memread;
   logic [2:0]  ID_EX_writeREG;
   logic        branch_taken, EX_MEM_memreq, mem_ready, perf_clr;
   logic        PCwrite, IF_ID_write, ID_EX_write, EX_MEM_write;
   logic        ID_EX_bubble, MEM_WB_bubble, IF_ID_flush, ID_EX_flush, PCsrc;
   logic [15:0] stall_cycles;
   logic        mem_timeout;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   bit mdl_waiting;   // memory access still outstanding
   int mdl_run;       // consecutive frozen cycles so far
   int mdl_stall;
   bit mdl_timeout;
   bit exp_pcw;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_readREG1(IF_ID_readREG1), .IF_ID_readREG2(IF_ID_readREG2),
      .IF_ID_uses2(IF_ID_uses2), .ID_EX_memread(ID_EX_memread),
      .ID_EX_writeREG(ID_EX_writeREG), .branch_taken(branch_taken),
      .EX_MEM_memreq(EX_MEM_memreq), .mem_ready(mem_ready), .perf_clr(perf_clr),
      .PCwrite(PCwrite), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
      .EX_MEM_write(EX_MEM_write), .ID_EX_bubble(ID_EX_bubble),
      .MEM_WB_bubble(MEM_WB_bubble), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .PCsrc(PCsrc),
      .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit model_freeze();
      return rst_n && !mem_ready && (EX_MEM_memreq || mdl_waiting);
   endfunction

   function automatic bit model_hazard();
      if (!ID_EX_memread || ID_EX_writeREG == 0) return 0;
      return (ID_EX_writeREG == IF_ID_readREG1) ||
             (IF_ID_uses2 && ID_EX_writeREG == IF_ID_readREG2);
   endfunction

   // Build the expected control word from the priority rules, then compare
   // every output against it.
   task automatic check_outputs(input string tag);
      bit [8:0] e;   // pcw ifw idw exw bub mwb iff idf pcs
      if (!rst_n)               e = 9'b0000_0000_0;
      else if (model_freeze())  e = 9'b0000_0100_0;
      else if (branch_taken)    e = 9'b1111_0001_1 | 9'b0000_0010_0;
      else if (model_hazard())  e = 9'b0011_1000_0;
      else                      e = 9'b1111_0000_0;
      exp_pcw = e[8];
      chk1({tag, ".PCwrite"},       PCwrite,       e[8]);
      chk1({tag, ".IF_ID_write"},   IF_ID_write,   e[7]);
      chk1({tag, ".ID_EX_write"},   ID_EX_write,   e[6]);
      chk1({tag, ".EX_MEM_write"},  EX_MEM_write,  e[5]);
      chk1({tag, ".ID_EX_bubble"},  ID_EX_bubble,  e[4]);
      chk1({tag, ".MEM_WB_bubble"}, MEM_WB_bubble, e[3]);
      chk1({tag, ".IF_ID_flush"},   IF_ID_flush,   e[2]);
      chk1({tag, ".ID_EX_flush"},   ID_EX_flush,   e[1]);
      chk1({tag, ".PCsrc"},         PCsrc,         e[0]);
      chk16({tag, ".stall_cycles"}, stall_cycles, 16'(mdl_stall));
      chk1({tag, ".mem_timeout"},   mem_timeout,   mdl_timeout);
   endtask

   // Inputs are already applied; check mid-cycle, then advance the model
   // across the rising edge.
   task automatic step(input string tag);
      bit frz;
      #3;
      check_outputs(tag);
      frz = model_freeze();
      @(posedge clk);
      if (perf_clr) begin
         mdl_stall   = 0;
         mdl_timeout = 0;
      end else begin
         if (frz && mdl_run >= 15) mdl_timeout = 1;
         if (!exp_pcw && mdl_stall < 65535) mdl_stall++;
      end
      mdl_run     = frz ? mdl_run + 1 : 0;
      mdl_waiting = frz;
      #1;
   endtask

   task automatic model_reset();
      mdl_waiting = 0;
      mdl_run     = 0;
      mdl_stall   = 0;
      mdl_timeout = 0;
   endtask

   task automatic idle_inputs();
      IF_ID_readREG1 = 3'd1; IF_ID_readREG2 = 3'd2; IF_ID_uses2 = 1'b0;
      ID_EX_memread = 1'b0; ID_EX_writeREG = 3'd0; branch_taken = 1'b0;
      EX_MEM_memreq = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 1'b0;
      #2;
      check_outputs("reset");
      chk16("reset.stall_const", stall_cycles, 16'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Quiet pipeline
      step("idle");

      // Load-use hazard through readREG2
      ID_EX_memread = 1; ID_EX_writeREG = 3; IF_ID_readREG1 = 5;
      IF_ID_readREG2 = 3; IF_ID_uses2 = 1;
      #3; chk1("loaduse.bubble_const", ID_EX_bubble, 1'b1); #0;
      step("loaduse");
      idle_inputs();
      step("after_loaduse");
      chk16("loaduse.stall_is_1", stall_cycles, 16'd1);

      // No false hazards
      ID_EX_memread = 1; ID_EX_writeREG = 0; IF_ID_readREG1 = 0;
      IF_ID_readREG2 = 0; IF_ID_uses2 = 1;
      step("nohaz.r0");
      ID_EX_memread = 1; ID_EX_writeREG = 3; IF_ID_readREG1 = 1;
      IF_ID_readREG2 = 3; IF_ID_uses2 = 0;
      step("nohaz.uses2_0");
      idle_inputs();
      perf_clr = 1;
      step("clr1");
      perf_clr = 0;

      // Three-cycle memory wait
      EX_MEM_memreq = 1; mem_ready = 0;
      for (int unsigned i = 0; i < 3; i++) step("memwait");
      mem_ready = 1;
      step("memwait.release");
      chk1("memwait.release_pcw", PCwrite, 1'b1);
      idle_inputs();
      step("memwait.after");
      chk16("memwait.stall_is_3", stall_cycles, 16'd3);

      // Branch with a simultaneous load-use hazard
      branch_taken = 1; ID_EX_memread = 1; ID_EX_writeREG = 2;
      IF_ID_readREG1 = 2;
      step("branch_lu");
      idle_inputs();

      // Timeout after 16 frozen cycles
      EX_MEM_memreq = 1; mem_ready = 0;
      for (int unsigned i = 0; i < 20; i++) step("timeout");
      chk1("timeout.sticky", mem_timeout, 1'b1);
      mem_ready = 1;
      step("timeout.release");
      idle_inputs();
      perf_clr = 1;
      step("timeout.clr");
      perf_clr = 0;
      step("timeout.after_clr");
      chk1("timeout.cleared", mem_timeout, 1'b0);

      // Branch arriving during a wait
      EX_MEM_memreq = 1; mem_ready = 0; branch_taken = 1;
      for (int unsigned i = 0; i < 2; i++) step("wait_branch");
      EX_MEM_memreq = 0; mem_ready = 1;
      step("wait_branch.release");
      idle_inputs();
      step("wait_branch.after");

      // Reset asserted in the middle of a wait
      EX_MEM_memreq = 1; mem_ready = 0;
      for (int unsigned i = 0; i < 3; i++) step("rstwait");
      rst_n = 0;
      model_reset();
      #2;
      check_outputs("rstwait.in_reset");
      @(posedge clk); #1;
      rst_n = 1;
      EX_MEM_memreq = 0; mem_ready = 0;
      step("rstwait.run_again");
      EX_MEM_memreq = 1;
      step("rstwait.reeval");

      // Randomised traffic
      idle_inputs();
      for (int unsigned i = 0; i < 600; i++) begin
         IF_ID_readREG1 = 3'($urandom_range(0, 7));
         IF_ID_readREG2 = 3'($urandom_range(0, 7));
         IF_ID_uses2    = 1'($urandom_range(0, 1));
         ID_EX_memread  = 1'($urandom_range(0, 1));
         ID_EX_writeREG = 3'($urandom_range(0, 7));
         branch_taken   = ($urandom_range(0, 3) == 0);
         EX_MEM_memreq  = ($urandom_range(0, 2) == 0);
         mem_ready      = (i % 100 < 30) ? 1'b0 : ($urandom_range(0, 1) == 1);
         perf_clr       = ($urandom_range(0, 63) == 0);
         step("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
